reg_file_cc: RTL and testbench
==============================

// Module: reg_file_cc
// PURPOSE
//   LC-3 general-purpose register file R0-R7 with condition-code (NZP) and BEN registers.
//   Consumes the eight per-register load enables from the destination-register demux.
//   Sits downstream of that demux. Supplies SR1/SR2 operands to the ALU/address path.
//   Supplies NZP/BEN to the control FSM. Multi-hot load enables are detected, blocked and counted.
// PARAMETERS
//   WIDTH   16  register/bus data width
//   BYPASS  1   1: same-cycle write data forwarded to read ports; 0: no forwarding
// PORTS
//   Clk        in   1      system clock, rising-edge
//   Reset      in   1      asynchronous, active-high reset
//   ld_reg1..8 in   1 ea   load enable for R0..R7 (ld_reg1 -> R0 ... ld_reg8 -> R7)
//   bus_in     in   WIDTH  write-back data from CPU bus
//   sr1_sel    in   3      read port 1 register index
//   sr2_sel    in   3      read port 2 register index
//   ld_cc      in   1      load NZP from bus_in
//   ld_ben     in   1      load BEN
//   ir_nzp     in   3      IR[11:9] branch condition mask
//   sr1_out    out  WIDTH  read port 1 data
//   sr2_out    out  WIDTH  read port 2 data
//   nzp        out  3      condition codes {N,Z,P}
//   ben        out  1      branch enable
//   ld_err     out  1      one-cycle pulse: previous edge saw >1 load enable
//   err_count  out  8      saturating count of multi-hot events
// BEHAVIOUR
//   Reset (async, immediate, any state):
//     - R0..R7 = 0, nzp = 3'b010, ben = 0, ld_err = 0, err_count = 0.
//     - A write pending at reset assertion is discarded.
//   Write (rising Clk edge):
//     - Popcount of ld_reg1..8 == 1: selected register <= bus_in.
//     - Popcount == 0: no write.
//     - Popcount > 1: no register written.
//       ld_err = 1 for exactly that next cycle.
//       err_count += 1, saturating at 8'hFF (no wrap).
//     - Popcount <= 1: ld_err = 0 next cycle.
//   Read (combinational, zero latency):
//     - srX_out = R[srX_sel].
//     - BYPASS=1 and a valid single write targets srX_sel this cycle: srX_out = bus_in.
//     - BYPASS=0: the new value is visible only after the edge.
//     - A blocked multi-hot write is never forwarded.
//     - Both ports may select the same register; both return identical data.
//   Condition codes (edge, ld_cc=1):
//     - nzp <= 3'b100 if bus_in[WIDTH-1].
//     - Else nzp <= 3'b010 if bus_in == 0.
//     - Else nzp <= 3'b001.
//     - Exactly one bit is ever set.
//     - Independent of load-enable validity; ld_cc=0 holds nzp.
//   BEN (edge, ld_ben=1):
//     - ben <= |(ir_nzp & nzp), using the registered (pre-edge) nzp.
//     - ld_cc and ld_ben in the same cycle: ben uses the old nzp.
//     - ld_ben=0 holds ben.
// TESTING
//   1. Reset, then read all 8 regs -> sr1_out = sr2_out = 0, nzp = 010, ben = 0, err_count = 0.
//   2. ld_reg4=1, bus_in=16'h1234, sr1_sel=3, BYPASS=1
//      -> sr1_out = 1234 same cycle; R3 = 1234 after edge; BYPASS=0 -> old value until edge.
//   3. ld_reg1 = ld_reg8 = 1, bus_in=FFFF
//      -> R0, R7 unchanged; ld_err pulses 1 cycle; err_count = 1; 256 repeats -> holds FF.
//   4. ld_cc with bus_in = 8000 / 0000 / 0001 -> nzp = 100 / 010 / 001.
//   5. nzp = 001; ld_cc (bus_in=0) and ld_ben (ir_nzp=001) same cycle
//      -> ben = 1, nzp = 010; next ld_ben with 001 -> ben = 0.
//   6. Reset asserted mid-cycle with ld_reg2=1 -> R1 stays 0; outputs reset without waiting for Clk.

Source files
------------

// File: rtl/reg_file_cc.sv
// LC-3 register file R0-R7 with NZP condition codes and branch-enable register.
// Multi-hot load enables are blocked, flagged for one cycle and counted (saturating).
module reg_file_cc #(
    parameter int WIDTH  = 16,
    parameter bit BYPASS = 1'b1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             ld_reg1,
    input  logic             ld_reg2,
    input  logic             ld_reg3,
    input  logic             ld_reg4,
    input  logic             ld_reg5,
    input  logic             ld_reg6,
    input  logic             ld_reg7,
    input  logic             ld_reg8,
    input  logic [WIDTH-1:0] bus_in,
    input  logic [2:0]       sr1_sel,
    input  logic [2:0]       sr2_sel,
    input  logic             ld_cc,
    input  logic             ld_ben,
    input  logic [2:0]       ir_nzp,
    output logic [WIDTH-1:0] sr1_out,
    output logic [WIDTH-1:0] sr2_out,
    output logic [2:0]       nzp,
    output logic             ben,
    output logic             ld_err,
    output logic [7:0]       err_count
);

    logic [7:0]       ld_vec;
    logic [3:0]       ld_pop;
    logic [2:0]       wr_idx;
    logic             ld_one;
    logic             ld_multi;
    logic [WIDTH-1:0] regs [8];
    logic [2:0]       nzp_next;
    logic             fwd1;
    logic             fwd2;

    assign ld_vec = {ld_reg8, ld_reg7, ld_reg6, ld_reg5,
                     ld_reg4, ld_reg3, ld_reg2, ld_reg1};

    always_comb begin
        ld_pop = '0;
        wr_idx = '0;
        for (int i = 0; i < 8; i++) begin
            ld_pop = ld_pop + {3'b000, ld_vec[i]};
            if (ld_vec[i]) begin
                wr_idx = 3'(i);
            end
        end
    end

    assign ld_one   = (ld_pop == 4'd1);
    assign ld_multi = (ld_pop > 4'd1);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else if (ld_one) begin
            regs[wr_idx] <= bus_in;
        end
    end

    // A write is not considered valid while reset is held, so it is not forwarded either.
    assign fwd1 = BYPASS && ld_one && !Reset && (wr_idx == sr1_sel);
    assign fwd2 = BYPASS && ld_one && !Reset && (wr_idx == sr2_sel);

    assign sr1_out = fwd1 ? bus_in : regs[sr1_sel];
    assign sr2_out = fwd2 ? bus_in : regs[sr2_sel];

    always_comb begin
        nzp_next = 3'b001;
        if (bus_in[WIDTH-1]) begin
            nzp_next = 3'b100;
        end else if (bus_in == '0) begin
            nzp_next = 3'b010;
        end
    end

    // ben samples the pre-edge nzp, so a simultaneous ld_cc does not affect it.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            nzp <= 3'b010;
            ben <= 1'b0;
        end else begin
            if (ld_cc) begin
                nzp <= nzp_next;
            end
            if (ld_ben) begin
                ben <= |(ir_nzp & nzp);
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ld_err    <= 1'b0;
            err_count <= '0;
        end else begin
            ld_err <= ld_multi;
            if (ld_multi && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_cc.sv
// Scoreboard bench for reg_file_cc: stimulus queues expected outputs per cycle,
// a monitor on the falling edge pops and compares against a BYPASS=1 and a BYPASS=0 instance.
module tb_reg_file_cc;

    logic        Clk;
    logic        Reset;
    logic [7:0]  ld;
    logic [15:0] bus_in;
    logic [2:0]  sr1_sel, sr2_sel, ir_nzp;
    logic        ld_cc, ld_ben;

    logic [15:0] sr1_out, sr2_out, sr1_nb, sr2_nb;
    logic [2:0]  nzp, nzp_nb;
    logic        ben, ben_nb, ld_err, ld_err_nb;
    logic [7:0]  err_count, err_count_nb;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [15:0] sr1, sr2, sr1nb, sr2nb;
        logic [2:0]  nzp;
        logic        ben, err;
        logic [7:0]  cnt;
    } exp_t;

    exp_t exp_q[$];

    logic [2:0] e_nzp;
    logic       e_ben, e_err;
    logic [7:0] e_cnt;

    reg_file_cc #(.WIDTH(16), .BYPASS(1'b1)) dut (
        .Clk(Clk), .Reset(Reset),
        .ld_reg1(ld[0]), .ld_reg2(ld[1]), .ld_reg3(ld[2]), .ld_reg4(ld[3]),
        .ld_reg5(ld[4]), .ld_reg6(ld[5]), .ld_reg7(ld[6]), .ld_reg8(ld[7]),
        .bus_in(bus_in), .sr1_sel(sr1_sel), .sr2_sel(sr2_sel),
        .ld_cc(ld_cc), .ld_ben(ld_ben), .ir_nzp(ir_nzp),
        .sr1_out(sr1_out), .sr2_out(sr2_out), .nzp(nzp), .ben(ben),
        .ld_err(ld_err), .err_count(err_count)
    );

    reg_file_cc #(.WIDTH(16), .BYPASS(1'b0)) dut_nb (
        .Clk(Clk), .Reset(Reset),
        .ld_reg1(ld[0]), .ld_reg2(ld[1]), .ld_reg3(ld[2]), .ld_reg4(ld[3]),
        .ld_reg5(ld[4]), .ld_reg6(ld[5]), .ld_reg7(ld[6]), .ld_reg8(ld[7]),
        .bus_in(bus_in), .sr1_sel(sr1_sel), .sr2_sel(sr2_sel),
        .ld_cc(ld_cc), .ld_ben(ld_ben), .ir_nzp(ir_nzp),
        .sr1_out(sr1_nb), .sr2_out(sr2_nb), .nzp(nzp_nb), .ben(ben_nb),
        .ld_err(ld_err_nb), .err_count(err_count_nb)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input string f, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s %s: got %0h expected %0h", nm, f, act, expv);
        end
    endtask

    // Monitor: outputs are stable mid-cycle; one queued expectation per falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.name, "sr1_out",      32'(sr1_out),      32'(e.sr1));
                chk(e.name, "sr2_out",      32'(sr2_out),      32'(e.sr2));
                chk(e.name, "sr1_out_nb",   32'(sr1_nb),       32'(e.sr1nb));
                chk(e.name, "sr2_out_nb",   32'(sr2_nb),       32'(e.sr2nb));
                chk(e.name, "nzp",          32'(nzp),          32'(e.nzp));
                chk(e.name, "ben",          32'(ben),          32'(e.ben));
                chk(e.name, "ld_err",       32'(ld_err),       32'(e.err));
                chk(e.name, "err_count",    32'(err_count),    32'(e.cnt));
                chk(e.name, "nzp_nb",       32'(nzp_nb),       32'(e.nzp));
                chk(e.name, "err_count_nb", 32'(err_count_nb), 32'(e.cnt));
            end
        end
    end

    task automatic cyc(input string nm, input logic [7:0] l, input logic [15:0] b,
                       input logic [2:0] s1, input logic [2:0] s2,
                       input logic cc, input logic bn, input logic [2:0] irn,
                       input logic [15:0] x1, input logic [15:0] x2,
                       input logic [15:0] x1nb, input logic [15:0] x2nb);
        exp_t e;
        @(posedge Clk);
        #1;
        ld = l; bus_in = b; sr1_sel = s1; sr2_sel = s2;
        ld_cc = cc; ld_ben = bn; ir_nzp = irn;
        e.name = nm; e.sr1 = x1; e.sr2 = x2; e.sr1nb = x1nb; e.sr2nb = x2nb;
        e.nzp = e_nzp; e.ben = e_ben; e.err = e_err; e.cnt = e_cnt;
        exp_q.push_back(e);
    endtask

    initial begin
        Reset = 1'b1; ld = '0; bus_in = '0; sr1_sel = '0; sr2_sel = '0;
        ld_cc = 1'b0; ld_ben = 1'b0; ir_nzp = '0;
        e_nzp = 3'b010; e_ben = 1'b0; e_err = 1'b0; e_cnt = 8'h00;

        cyc("reset", 8'h00, 16'h0000, 3'd0, 3'd7, 0, 0, 3'b000, 16'h0, 16'h0, 16'h0, 16'h0);
        Reset = 1'b0;

        for (int i = 0; i < 8; i++)
            cyc("read_zero", 8'h00, 16'h0000, 3'(i), 3'(7 - i), 0, 0, 3'b000,
                16'h0, 16'h0, 16'h0, 16'h0);

        // single writes, forwarding vs. no forwarding
        cyc("byp_r3",       8'h08, 16'h1234, 3'd3, 3'd3, 0, 0, 3'b000, 16'h1234, 16'h1234, 16'h0000, 16'h0000);
        cyc("r3_after",     8'h00, 16'h0000, 3'd3, 3'd0, 0, 0, 3'b000, 16'h1234, 16'h0000, 16'h1234, 16'h0000);
        cyc("byp_r3_ovr",   8'h08, 16'h5678, 3'd3, 3'd3, 0, 0, 3'b000, 16'h5678, 16'h5678, 16'h1234, 16'h1234);
        cyc("r3_ovr_after", 8'h00, 16'h0000, 3'd3, 3'd3, 0, 0, 3'b000, 16'h5678, 16'h5678, 16'h5678, 16'h5678);
        cyc("fwd_other",    8'h20, 16'h00A5, 3'd3, 3'd5, 0, 0, 3'b000, 16'h5678, 16'h00A5, 16'h5678, 16'h0000);
        cyc("r5_after",     8'h00, 16'h0000, 3'd5, 3'd5, 0, 0, 3'b000, 16'h00A5, 16'h00A5, 16'h00A5, 16'h00A5);

        // multi-hot blocking, error pulse and saturation
        cyc("w_r0",        8'h01, 16'h1111, 3'd0, 3'd0, 0, 0, 3'b000, 16'h1111, 16'h1111, 16'h0000, 16'h0000);
        cyc("w_r7",        8'h80, 16'h7777, 3'd0, 3'd7, 0, 0, 3'b000, 16'h1111, 16'h7777, 16'h1111, 16'h0000);
        cyc("multi_first", 8'h81, 16'hFFFF, 3'd0, 3'd7, 0, 0, 3'b000, 16'h1111, 16'h7777, 16'h1111, 16'h7777);
        e_err = 1'b1; e_cnt = 8'h01;
        cyc("multi_pulse", 8'h00, 16'h0000, 3'd0, 3'd7, 0, 0, 3'b000, 16'h1111, 16'h7777, 16'h1111, 16'h7777);
        e_err = 1'b0;
        cyc("multi_clear", 8'h00, 16'h0000, 3'd0, 3'd7, 0, 0, 3'b000, 16'h1111, 16'h7777, 16'h1111, 16'h7777);
        for (int k = 0; k < 256; k++) begin
            e_err = (k > 0);
            e_cnt = (k + 1 > 255) ? 8'hFF : 8'(k + 1);
            cyc("multi_sat", 8'h81, 16'hFFFF, 3'd0, 3'd7, 0, 0, 3'b000, 16'h1111, 16'h7777, 16'h1111, 16'h7777);
        end
        e_err = 1'b1; e_cnt = 8'hFF;
        cyc("sat_hold",  8'h00, 16'h0000, 3'd0, 3'd7, 0, 0, 3'b000, 16'h1111, 16'h7777, 16'h1111, 16'h7777);
        e_err = 1'b0;
        cyc("sat_clear", 8'h00, 16'h0000, 3'd0, 3'd7, 0, 0, 3'b000, 16'h1111, 16'h7777, 16'h1111, 16'h7777);

        // condition codes
        cyc("cc_neg_pre", 8'h00, 16'h8000, 3'd0, 3'd7, 1, 0, 3'b000, 16'h1111, 16'h7777, 16'h1111, 16'h7777);
        e_nzp = 3'b100;
        cyc("cc_zero",    8'h00, 16'h0000, 3'd0, 3'd7, 1, 0, 3'b000, 16'h1111, 16'h7777, 16'h1111, 16'h7777);
        e_nzp = 3'b010;
        cyc("cc_pos",     8'h00, 16'h0001, 3'd0, 3'd7, 1, 0, 3'b000, 16'h1111, 16'h7777, 16'h1111, 16'h7777);
        e_nzp = 3'b001;
        cyc("cc_hold",    8'h00, 16'h8000, 3'd0, 3'd7, 0, 0, 3'b000, 16'h1111, 16'h7777, 16'h1111, 16'h7777);
        cyc("cc_hold2",   8'h00, 16'h8000, 3'd0, 3'd7, 0, 0, 3'b000, 16'h1111, 16'h7777, 16'h1111, 16'h7777);

        // ben uses pre-edge nzp
        cyc("ben_same_cyc", 8'h00, 16'h0000, 3'd0, 3'd7, 1, 1, 3'b001, 16'h1111, 16'h7777, 16'h1111, 16'h7777);
        e_nzp = 3'b010; e_ben = 1'b1;
        cyc("ben_old_nzp",  8'h00, 16'h0000, 3'd0, 3'd7, 0, 1, 3'b001, 16'h1111, 16'h7777, 16'h1111, 16'h7777);
        e_ben = 1'b0;
        cyc("ben_clear",    8'h00, 16'h0000, 3'd0, 3'd7, 0, 1, 3'b110, 16'h1111, 16'h7777, 16'h1111, 16'h7777);
        e_ben = 1'b1;
        cyc("ben_mask",     8'h00, 16'h0000, 3'd0, 3'd7, 0, 0, 3'b000, 16'h1111, 16'h7777, 16'h1111, 16'h7777);
        cyc("ben_hold",     8'h00, 16'h0000, 3'd0, 3'd7, 0, 0, 3'b000, 16'h1111, 16'h7777, 16'h1111, 16'h7777);

        // ld_cc still acts when the register load is blocked
        cyc("cc_multi",       8'h03, 16'h8001, 3'd0, 3'd1, 1, 0, 3'b000, 16'h1111, 16'h0000, 16'h1111, 16'h0000);
        e_nzp = 3'b100; e_err = 1'b1;
        cyc("cc_multi_after", 8'h00, 16'h0000, 3'd0, 3'd1, 0, 0, 3'b000, 16'h1111, 16'h0000, 16'h1111, 16'h0000);
        e_err = 1'b0;

        // asynchronous reset with a pending write
        cyc("w_r1",     8'h02, 16'h5555, 3'd1, 3'd1, 0, 0, 3'b000, 16'h5555, 16'h5555, 16'h0000, 16'h0000);
        cyc("r1_after", 8'h00, 16'h0000, 3'd1, 3'd1, 0, 0, 3'b000, 16'h5555, 16'h5555, 16'h5555, 16'h5555);
        e_nzp = 3'b010; e_ben = 1'b0; e_err = 1'b0; e_cnt = 8'h00;
        cyc("rst_mid",  8'h02, 16'hABCD, 3'd0, 3'd7, 0, 0, 3'b000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        Reset = 1'b1;
        cyc("rst_hold", 8'h02, 16'hABCD, 3'd0, 3'd7, 0, 0, 3'b000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        Reset = 1'b0; ld = 8'h00;
        cyc("rst_r1",   8'h00, 16'h0000, 3'd1, 3'd1, 0, 0, 3'b000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        cyc("rst_r0r7", 8'h00, 16'h0000, 3'd7, 3'd0, 0, 0, 3'b000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);

        repeat (2) @(negedge Clk);
        #1;
        chk("drain", "queue_left", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
